// File: rtl/multiplexor_display.sv
// ---------------------------------------------------------------------------
// multiplexor_display
//
// Four-digit, time-multiplexed driver for a common-anode seven-segment
// display. Each digit gets one slot of REFRESH_DIV cycles. A slot starts with
// BLANK_CYCLES cycles in which every anode is off, which prevents ghosting,
// and then shows the digit. Codes written with load go into a pending buffer.
// That buffer is copied into the display buffer only at a frame boundary, so
// a single frame never mixes old and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, digit 3 is shown blank when its stored code is "0". The
//   anode still scans, so the timing is unchanged.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous reset, active-low
//   seg_in0..3  digit codes, abcdefg (bit6 = a), active-low; digit 0 = rightmost
//   dp_in       decimal-point requests, 1 = lit, bit i -> digit i
//   load        single-cycle strobe that captures seg_in0..3 / dp_in
//   an          anode enables, active-low, bit i -> digit i
//   seg         segment drive, abcdefg, active-low
//   dp_n        decimal-point drive, active-low
//   frame_done  one-cycle pulse as the outputs enter BLANK for digit 0
// ---------------------------------------------------------------------------
module multiplexor_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in0,
    input  logic [6:0] seg_in1,
    input  logic [6:0] seg_in2,
    input  logic [6:0] seg_in3,
    input  logic [3:0] dp_in,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic       frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    SEG_OFF    = 7'b1111111;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]  idx, idx_d;
    logic        boundary;

    logic [6:0]  pend_seg [4];
    logic [3:0]  pend_dp;
    logic        pend_valid;
    logic [6:0]  disp_seg [4];
    logic [3:0]  disp_dp;

    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_n_d;

    // Next-state logic. The output drive is decoded from the next state, so
    // the registered outputs line up with the state/counter they describe.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt + CW'(1);
        idx_d    = idx;
        boundary = (cnt == SLOT_LAST) && (idx == 2'd3);
        an_d     = 4'b1111;
        seg_d    = SEG_OFF;
        dp_n_d   = 1'b1;

        case (state)
            BLANK: if (cnt == BLANK_LAST) state_d = SHOW;
            SHOW:  if (cnt == SLOT_LAST) begin
                       state_d = BLANK;
                       idx_d   = idx + 2'd1;
                   end
            default: state_d = BLANK;
        endcase
        if (cnt == SLOT_LAST) cnt_d = '0;

        if (state_d == SHOW) begin
            an_d   = ~(4'b0001 << idx_d);
            seg_d  = disp_seg[idx_d];
            dp_n_d = ~disp_dp[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
            if (idx_d == 2'd3 && disp_seg[3] == 7'b0000001) begin
                seg_d  = SEG_OFF;
                dp_n_d = 1'b1;
            end
`endif
        end
    end

    // Scan state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            idx        <= idx_d;
            an         <= an_d;
            seg        <= seg_d;
            dp_n       <= dp_n_d;
            frame_done <= boundary;
        end
    end

    // Double buffer. The boundary copy reads the pending registers as they
    // were before this edge. A load on the same edge therefore waits for the
    // next frame and keeps pend_valid set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pend_seg[i] <= SEG_OFF;
                disp_seg[i] <= SEG_OFF;
            end
            pend_dp    <= 4'b0000;
            disp_dp    <= 4'b0000;
            pend_valid <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                for (int i = 0; i < 4; i++) disp_seg[i] <= pend_seg[i];
                disp_dp    <= pend_dp;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_seg[0] <= seg_in0;
                pend_seg[1] <= seg_in1;
                pend_seg[2] <= seg_in2;
                pend_seg[3] <= seg_in3;
                pend_dp     <= dp_in;
                pend_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiplexor_display.sv
module tb_multiplexor_display;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * RD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in0, seg_in1, seg_in2, seg_in3;
    logic [3:0] dp_in;
    logic       load;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    bit run = 0;

    multiplexor_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n),
        .seg_in0(seg_in0), .seg_in1(seg_in1), .seg_in2(seg_in2), .seg_in3(seg_in3),
        .dp_in(dp_in), .load(load),
        .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: k = clock edges since reset release. Position in the frame
    // gives the slot and digit directly; buffers are plain arrays.
    int         k;
    logic [6:0] m_pend [4];
    logic [6:0] m_disp [4];
    logic [3:0] m_pdp, m_ddp;
    bit         m_pv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 0;
            m_pv <= 0;
            m_pdp <= 4'b0;
            m_ddp <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] <= 7'h7F;
                m_disp[i] <= 7'h7F;
            end
        end else begin
            if (k % FRAME == FRAME - 1 && m_pv) begin
                for (int i = 0; i < 4; i++) m_disp[i] <= m_pend[i];
                m_ddp <= m_pdp;
                m_pv  <= 0;
            end
            if (load) begin
                m_pend[0] <= seg_in0;
                m_pend[1] <= seg_in1;
                m_pend[2] <= seg_in2;
                m_pend[3] <= seg_in3;
                m_pdp     <= dp_in;
                m_pv      <= 1;
            end
            k <= k + 1;
        end
    end

    int         e_slot, e_dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;

    always @(negedge clk) begin
        if (rst_n && run) begin
            e_slot = k % RD;
            e_dig  = (k / RD) % 4;
            e_fd   = (k > 0) && (k % FRAME == 0);
            if (e_slot < BC) begin
                e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = 4'b1111;
                e_an[e_dig] = 1'b0;
                e_seg = m_disp[e_dig];
                e_dp  = ~m_ddp[e_dig];
`ifdef LEADING_ZERO_BLANK_EN
                if (e_dig == 3 && m_disp[3] == 7'b0000001) begin
                    e_seg = 7'h7F; e_dp = 1'b1;
                end
`endif
            end
            chk("an", an, e_an);
            chk("seg", seg, e_seg);
            chk("dp_n", dp_n, e_dp);
            chk("frame_done", frame_done, e_fd);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [6:0] a, b, c, d, input logic [3:0] p);
        seg_in0 = a; seg_in1 = b; seg_in2 = c; seg_in3 = d; dp_in = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Advances to the next negedge where frame_done is high; returns cycles.
    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) begin
            errors++;
            checks++;
            $display("FAIL frame_done_timeout got none within %0d cycles", n);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; load = 1'b0;
        seg_in0 = 7'h7F; seg_in1 = 7'h7F; seg_in2 = 7'h7F; seg_in3 = 7'h7F; dp_in = 4'b0;
        step(3);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dp", dp_n, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;
        run = 1;
        step(1);
        chk("blank2_an", an, 4'b1111);
        step(1);
        chk("first_show_an", an, 4'b1110);
        chk("first_show_seg", seg, 7'b1111111);

        // Full scan of "3210", decimal point on digit 2
        do_load(7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 4'b0100);
        wait_fd(n);
        step(2);
        chk("scan_d0_an", an, 4'b1110);
        chk("scan_d0_seg", seg, 7'b0000001);
        chk("scan_d0_dp", dp_n, 1'b1);
        step(16);
        chk("scan_d2_an", an, 4'b1011);
        chk("scan_d2_seg", seg, 7'b0010010);
        chk("scan_d2_dp", dp_n, 1'b0);
        step(8);
        chk("scan_d3_an", an, 4'b0111);
        chk("scan_d3_seg", seg, 7'b0000110);
        wait_fd(n);
        wait_fd(n);
        chk("frame_period", n, 32);

        // Tear-free: load during digit 2 SHOW
        step(19);
        do_load(7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 4'b0001);
        step(7);
        chk("tear_d3_old", seg, 7'b0000110);
        wait_fd(n);
        step(2);
        chk("tear_d0_new", seg, 7'b1001100);
        chk("tear_d0_dp", dp_n, 1'b0);

        // Collision: load sampled on the boundary edge itself
        step(29);
        do_load(7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 4'b1000);
        chk("coll_fd", frame_done, 1'b1);
        step(2);
        chk("coll_old", seg, 7'b1001100);
        wait_fd(n);
        step(2);
        chk("coll_new", seg, 7'b0000000);
        step(24);
        chk("coll_d3_an", an, 4'b0111);
        chk("coll_d3_seg", seg, 7'b1100000);
        chk("coll_d3_dp", dp_n, 1'b0);

        // Asynchronous reset during digit 1 SHOW
        wait_fd(n);
        step(11);
        chk("pre_rst_an", an, 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", an, 4'b1111);
        chk("async_seg", seg, 7'b1111111);
        chk("async_dp", dp_n, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("restart_an", an, 4'b1110);
        chk("restart_seg", seg, 7'b1111111);

        // Leading zero on digit 3
        do_load(7'b0010010, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1000);
        wait_fd(n);
        step(26);
        chk("lz_an", an, 4'b0111);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_seg", seg, 7'b1111111);
        chk("lz_dp", dp_n, 1'b1);
`else
        chk("lz_seg", seg, 7'b0000001);
        chk("lz_dp", dp_n, 1'b0);
`endif
        do_load(7'b0010010, 7'b0000001, 7'b0000001, 7'b1001111, 4'b0000);
        wait_fd(n);
        step(26);
        chk("nz_seg", seg, 7'b1001111);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplexor_display.md
Name: multiplexor_display

Overview:
- Four-digit time-multiplexed driver for a common-anode seven-segment display; the consuming end of the clock's segment encoders.
- Accepts four active-low abcdefg codes plus decimal-point requests and scans one digit at a time, with a blanking gap between digits to prevent ghosting.
- New codes are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (blank + show); legal range ≥ 2.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; legal range 1 .. REFRESH_DIV-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active-low.
- seg_in0  input  7  digit 0 code (rightmost digit), abcdefg, bit6 = a, 0 = segment lit.
- seg_in1  input  7  digit 1 code, same format.
- seg_in2  input  7  digit 2 code, same format.
- seg_in3  input  7  digit 3 code (leftmost digit), same format.
- dp_in  input  4  decimal-point request per digit, 1 = lit; bit i maps to digit i.
- load  input  1  single-cycle strobe; captures seg_in0..3 and dp_in into the pending buffer.
- an  output  4  anode enables, active-low; bit i = digit i.
- seg  output  7  segment drive, abcdefg, active-low.
- dp_n  output  1  decimal-point drive, active-low.
- frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - an=4'b1111, seg=7'b1111111, dp_n=1, frame_done=0.
  - Slot counter=0, digit index=0, state=BLANK.
  - Pending and display registers = 7'b1111111 / dp 0; pending_valid=0.
  - The first slot after reset release is a BLANK slot for digit 0.
- Buffering:
  - load=1 writes the pending registers and sets pending_valid.
  - At the frame boundary (the cycle that enters BLANK for digit 0), if pending_valid=1, pending is copied to display and pending_valid is cleared.
  - The boundary copy uses register values from before that cycle. A load in the same cycle as the boundary therefore appears in the next frame, and pending_valid stays 1.
  - Back-to-back loads within one frame: the last one wins.
- State machine, two states per slot:
  - BLANK: an=1111, seg=1111111, dp_n=1 for BLANK_CYCLES cycles (counter 0..BLANK_CYCLES-1).
  - SHOW: an has only bit[index] low; seg = display code[index]; dp_n = ~display_dp[index]. Lasts while counter runs BLANK_CYCLES..REFRESH_DIV-1.
  - When counter = REFRESH_DIV-1: counter→0, index→index+1 (wraps 3→0), state→BLANK.
- Counter width is $clog2(REFRESH_DIV); it never exceeds REFRESH_DIV-1.
- Outputs are registered: changes to an/seg/dp_n take effect the cycle after the state/counter condition.
- frame_done is asserted for exactly one cycle, concurrent with the outputs entering BLANK for digit 0, every 4*REFRESH_DIV cycles. It is not asserted for the first slot after reset.
- Exactly one anode is low during SHOW; all anodes are high during BLANK. Two anodes are never low at once, including at the transition cycle.
- Reset asserted mid-slot: outputs go to reset values immediately; pending data is lost.
- seg_in*/dp_in are sampled only on load; changes without load have no effect.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during the SHOW slot of digit 3, if display code[3] == 7'b0000001 (digit "0"), seg is forced to 7'b1111111 and dp_n to 1, but an[3] is still driven low. Timing is unchanged. This blanks the tens-of-hours zero (e.g. shows " 9" not "09").
- Not defined: digit 3 is displayed exactly as stored.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, frame = 32 cycles):
- Reset check: hold rst_n low, then release → an=1111, seg=1111111, dp_n=1 for 2 cycles; then an=1110 and seg=1111111 for 6 cycles (display still at reset value).
- Full scan: load seg_in0..3 = 0000001/1001111/0010010/0000110, dp_in=0100, then wait for frame_done → next frame shows an=1110/1101/1011/0111 with seg = "0"/"1"/"2"/"3"; dp_n=0 only while an=1011; each digit has a 2-cycle all-off gap; frame_done repeats every 32 cycles.
- Tear-free update: load new codes mid-frame (during digit 2 SHOW) → digits 2 and 3 of the current frame keep the old codes; new codes appear starting at digit 0 of the next frame.
- Boundary collision: assert load on the same cycle frame_done fires → that frame shows the old codes; the following frame shows the new codes.
- Reset mid-operation: drop rst_n during digit 1 SHOW → an=1111 in the same cycle without waiting for a clock edge; after release, scanning restarts at digit 0 BLANK.
- LEADING_ZERO_BLANK_EN defined, seg_in3=0000001 → during an=0111, seg=1111111; with seg_in3=1001111, seg=1001111.
